ex_operand_stage: RTL and testbench
===================================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX operand stage of the 8-bit pipelined MIPS core; feeds the EX-stage 2:1 operand muxes.
//  Registers decoded operands from ID and tracks destination registers held in EX/MEM.
//  Drives mux select (0 = regfile operand, 1 = bypassed value) plus the bypass value per operand.
//  Detects load-use hazards, inserts a one-cycle bubble, honours branch flush, counts stalls.
// PARAMETERS
//  DATA_W   8   operand/result width
//  REG_W    3   register-address width (8 registers; r0 reads 0, never forwarded)
//  CNT_W   16   stall-counter width
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-high
//  id_valid       in   1       ID holds a valid instruction
//  id_rs,id_rt    in   REG_W   source registers
//  id_rd          in   REG_W   destination register
//  id_rs_data     in   DATA_W  regfile read of rs
//  id_rt_data     in   DATA_W  regfile read of rt
//  id_reg_write   in   1       instruction writes rd
//  id_mem_read    in   1       instruction is a load
//  flush          in   1       branch taken: kill the instruction entering EX
//  ex_result      in   DATA_W  ALU result of the current EX instruction
//  wb_valid,wb_reg_write in 1  WB stage writes the regfile
//  wb_rd          in   REG_W   WB destination
//  wb_data        in   DATA_W  WB write value (ALU or load data)
//  id_ready       out  1       0 = ID must hold (load-use stall)
//  ex_valid       out  1       EX holds a valid instruction
//  ex_rs,ex_rt,ex_rd out REG_W registered addresses
//  ex_rs_data,ex_rt_data out DATA_W registered regfile operands (mux data_1)
//  ex_reg_write,ex_mem_read out 1 registered controls
//  fwd_sel_a,fwd_sel_b out 1   mux select for operand A (rs) / B (rt)
//  fwd_data_a,fwd_data_b out DATA_W bypass value (mux data_2)
//  stall_count    out  CNT_W   saturating count of stall cycles
// BEHAVIOUR
//  Reset (async, any cycle, mid-stall included): all ID/EX and EX/MEM regs 0, ex_valid=0,
//   mem_valid=0, stall_count=0; outputs thus fwd_sel_*=0, fwd_data_*=0, id_ready=1.
//  Hazard (comb): stall = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
//  id_ready = ~stall | flush.
//  ID/EX update each edge: flush -> ex_valid<=0; else stall -> ex_valid<=0 (bubble), ID held;
//   else capture all id_* fields, ex_valid<=id_valid. Flush beats stall.
//  EX/MEM update each edge: mem_valid<=ex_valid, mem_rd<=ex_rd, mem_reg_write<=ex_reg_write,
//   mem_mem_read<=ex_mem_read, mem_data<=ex_result. Not affected by stall or flush.
//  Forward (comb, per operand, src = ex_rs or ex_rt):
//   mem_hit = mem_valid & mem_reg_write & ~mem_mem_read & mem_rd==src & src!=0
//   wb_hit  = wb_valid & wb_reg_write & wb_rd==src & src!=0
//   sel = mem_hit|wb_hit; data = mem_hit ? mem_data : (wb_hit ? wb_data : 0). MEM beats WB.
//   Both forced 0 when ex_valid=0.
//  Load in MEM never forwards; load-use stall guarantees consumer meets load in WB.
//  Latency: 1 cycle ID->EX; 1 bubble per load-use; stall never exceeds 1 consecutive cycle.
//  stall_count += 1 on every stall & ~flush cycle; holds at all-ones (no wrap).
// STRUCTURE
//  Shared include pipe_defs.vh: DATA_W, REG_W, FWD_REGFILE=1'b0, FWD_BYPASS=1'b1, REG_ZERO.
//  One sub-module: hazard_detect (comb load-use compare, outputs stall).
//  Forward compare written once as a function, instanced for A and B.
// TESTING
//  Reset mid-stall: assert reset during bubble -> ex_valid=0, id_ready=1, stall_count=0 same cycle.
//  ALU chain: add r1 then sub r2,r1,r3 -> consumer in EX: fwd_sel_a=1, fwd_data_a=mem_data (0x2A).
//  MEM vs WB: r4 in MEM=0x11 and WB=0x22 -> fwd_data=0x11; only WB hit -> 0x22.
//  Load-use: lw r5 then add r6,r5,r5 -> id_ready=0 one cycle, bubble, then sel_a=sel_b=1 from wb_data.
//  r0: write/read r0 -> fwd_sel=0 always; flush+stall same cycle -> ex_valid=0, stall_count unchanged.
//  Saturation: preload CNT_W=4, 20 stalls -> stall_count=4'hF.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared pipeline definitions for the 8-bit MIPS ID/EX operand stage.
// Covers operand widths, register-zero encoding and the EX operand-mux select encoding.
package ex_operand_stage_pkg;
  localparam int PIPE_DATA_W = 8;
  localparam int PIPE_REG_W  = 3;
  localparam int PIPE_CNT_W  = 16;

  localparam logic FWD_REGFILE = 1'b0;
  localparam logic FWD_BYPASS  = 1'b1;

  localparam logic [PIPE_REG_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/ex_operand_stage_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load sitting in EX.
// The result is purely combinational; the caller turns it into a bubble.
module hazard_detect
  import ex_operand_stage_pkg::*;
#(
  parameter int REG_W = PIPE_REG_W
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             stall
);

  logic rd_nonzero;
  logic src_match;

  // A load into r0 never produces a value anyone can consume.
  assign rd_nonzero = (ex_rd != REG_W'(REG_ZERO));
  assign src_match  = (ex_rd == id_rs) | (ex_rd == id_rt);
  assign stall      = id_valid & ex_valid & ex_mem_read & rd_nonzero & src_match;

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: registers decoded operands, tracks the EX/MEM destination,
// drives per-operand bypass select/data and inserts a bubble on load-use hazards.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int REG_W  = PIPE_REG_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              fwd_sel_a,
  output logic              fwd_sel_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic [CNT_W-1:0]  stall_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

  // Returns {select, bypass data}; a non-load result in MEM beats WB.
  function automatic logic [DATA_W:0] fwd_pick(
    input logic              ex_vld,
    input logic [REG_W-1:0]  src,
    input logic              m_vld,
    input logic              m_rw,
    input logic              m_mr,
    input logic [REG_W-1:0]  m_rd,
    input logic [DATA_W-1:0] m_data,
    input logic              w_vld,
    input logic              w_rw,
    input logic [REG_W-1:0]  w_rd,
    input logic [DATA_W-1:0] w_data
  );
    logic              src_nz;
    logic              mem_hit;
    logic              wb_hit;
    logic [DATA_W-1:0] data;
    src_nz  = (src != REG_W'(REG_ZERO));
    mem_hit = ex_vld & m_vld & m_rw & ~m_mr & (m_rd == src) & src_nz;
    wb_hit  = ex_vld & w_vld & w_rw & (w_rd == src) & src_nz;
    if (mem_hit)
      data = m_data;
    else if (wb_hit)
      data = w_data;
    else
      data = '0;
    return {((mem_hit | wb_hit) ? FWD_BYPASS : FWD_REGFILE), data};
  endfunction

  logic              stall;

  logic              vld_p1;
  logic [REG_W-1:0]  rs_p1;
  logic [REG_W-1:0]  rt_p1;
  logic [REG_W-1:0]  rd_p1;
  logic [DATA_W-1:0] rs_data_p1;
  logic [DATA_W-1:0] rt_data_p1;
  logic              reg_write_p1;
  logic              mem_read_p1;

  logic              vld_p2;
  logic [REG_W-1:0]  rd_p2;
  logic              reg_write_p2;
  logic              mem_read_p2;
  logic [DATA_W-1:0] data_p2;

  logic [CNT_W-1:0]  stall_cnt;
  logic [DATA_W:0]   fwd_a;
  logic [DATA_W:0]   fwd_b;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_valid    (vld_p1),
    .ex_mem_read (mem_read_p1),
    .ex_rd       (rd_p1),
    .stall       (stall)
  );

  // A taken branch kills the stalled instruction anyway, so ID may advance.
  assign id_ready = ~stall | flush;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      rs_p1        <= '0;
      rt_p1        <= '0;
      rd_p1        <= '0;
      rs_data_p1   <= '0;
      rt_data_p1   <= '0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
    end else if (flush || stall) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1       <= id_valid;
      rs_p1        <= id_rs;
      rt_p1        <= id_rt;
      rd_p1        <= id_rd;
      rs_data_p1   <= id_rs_data;
      rt_data_p1   <= id_rt_data;
      reg_write_p1 <= id_reg_write;
      mem_read_p1  <= id_mem_read;
    end
  end

  // ---- EX -> MEM boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2       <= 1'b0;
      rd_p2        <= '0;
      reg_write_p2 <= 1'b0;
      mem_read_p2  <= 1'b0;
      data_p2      <= '0;
    end else begin
      vld_p2       <= vld_p1;
      rd_p2        <= rd_p1;
      reg_write_p2 <= reg_write_p1;
      mem_read_p2  <= mem_read_p1;
      data_p2      <= ex_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && !flush)
      stall_cnt <= sat_inc(stall_cnt);
  end

  assign fwd_a = fwd_pick(vld_p1, rs_p1, vld_p2, reg_write_p2, mem_read_p2, rd_p2, data_p2,
                          wb_valid, wb_reg_write, wb_rd, wb_data);
  assign fwd_b = fwd_pick(vld_p1, rt_p1, vld_p2, reg_write_p2, mem_read_p2, rd_p2, data_p2,
                          wb_valid, wb_reg_write, wb_rd, wb_data);

  assign fwd_sel_a  = fwd_a[DATA_W];
  assign fwd_data_a = fwd_a[DATA_W-1:0];
  assign fwd_sel_b  = fwd_b[DATA_W];
  assign fwd_data_b = fwd_b[DATA_W-1:0];

  assign ex_valid     = vld_p1;
  assign ex_rs        = rs_p1;
  assign ex_rt        = rt_p1;
  assign ex_rd        = rd_p1;
  assign ex_rs_data   = rs_data_p1;
  assign ex_rt_data   = rt_data_p1;
  assign ex_reg_write = reg_write_p1;
  assign ex_mem_read  = mem_read_p1;
  assign stall_count  = stall_cnt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed steps push expected observations,
// an independent monitor samples both DUT instances and compares.
module tb_ex_operand_stage;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [2:0] id_rs, id_rt, id_rd;
  logic [7:0] id_rs_data, id_rt_data;
  logic       id_reg_write, id_mem_read;
  logic       flush;
  logic [7:0] ex_result;
  logic       wb_valid, wb_reg_write;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;

  logic        id_ready, ex_valid, ex_reg_write, ex_mem_read;
  logic [2:0]  ex_rs, ex_rt, ex_rd;
  logic [7:0]  ex_rs_data, ex_rt_data;
  logic        fwd_sel_a, fwd_sel_b;
  logic [7:0]  fwd_data_a, fwd_data_b;
  logic [15:0] stall_count;

  logic        s_id_ready, s_ex_valid, s_ex_reg_write, s_ex_mem_read;
  logic [2:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic [7:0]  s_ex_rs_data, s_ex_rt_data;
  logic        s_fwd_sel_a, s_fwd_sel_b;
  logic [7:0]  s_fwd_data_a, s_fwd_data_b;
  logic [3:0]  s_stall_count;

  typedef struct {
    string name;
    int ev, rdy, sa, sb, da, db, cnt, cnt4;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .ex_result(ex_result), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .fwd_data_a(fwd_data_a),
    .fwd_data_b(fwd_data_b), .stall_count(stall_count)
  );

  ex_operand_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .ex_result(ex_result), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .id_ready(s_id_ready),
    .ex_valid(s_ex_valid), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
    .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data), .ex_reg_write(s_ex_reg_write),
    .ex_mem_read(s_ex_mem_read), .fwd_sel_a(s_fwd_sel_a), .fwd_sel_b(s_fwd_sel_b),
    .fwd_data_a(s_fwd_data_a), .fwd_data_b(s_fwd_data_b), .stall_count(s_stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input string fld, input int act, input int expv);
    if (expv >= 0) begin
      checks++;
      if (act != expv) begin
        errors++;
        $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, expv);
      end
    end
  endtask

  // Monitor: observes mid-cycle, well after stimulus settles and away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.name, "ex_valid",   int'(ex_valid),      e.ev);
        chk(e.name, "id_ready",   int'(id_ready),      e.rdy);
        chk(e.name, "fwd_sel_a",  int'(fwd_sel_a),     e.sa);
        chk(e.name, "fwd_sel_b",  int'(fwd_sel_b),     e.sb);
        chk(e.name, "fwd_data_a", int'(fwd_data_a),    e.da);
        chk(e.name, "fwd_data_b", int'(fwd_data_b),    e.db);
        chk(e.name, "stall_cnt",  int'(stall_count),   e.cnt);
        chk(e.name, "stall_cnt4", int'(s_stall_count), e.cnt4);
      end
    end
  end

  task automatic idle_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0;
    id_reg_write = 0; id_mem_read = 0; flush = 0; ex_result = 0;
    wb_valid = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    id_rs_data = 8'hA0 + 8'(rs); id_rt_data = 8'hB0 + 8'(rt);
  endtask

  task automatic set_wb(input logic [2:0] rd, input logic [7:0] d);
    wb_valid = 1; wb_reg_write = 1; wb_rd = rd; wb_data = d;
  endtask

  task automatic push(input string nm, input int ev, input int rdy, input int sa, input int sb,
                      input int da, input int db, input int cnt, input int cnt4);
    exp_t e;
    e.name = nm; e.ev = ev; e.rdy = rdy; e.sa = sa; e.sb = sb;
    e.da = da; e.db = db; e.cnt = cnt; e.cnt4 = cnt4;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    int waited;
    reset = 1;
    idle_inputs();

    step(); push("reset", 0, 1, 0, 0, 0, 0, 0, 0);
    step(); reset = 0; set_id(1, 2, 3, 1, 1, 0);
    push("idle_after_reset", 0, 1, 0, 0, 0, 0, 0, 0);
    step(); set_id(1, 1, 3, 2, 1, 0); ex_result = 8'h2A;
    push("add_in_ex", 1, 1, 0, 0, 0, 0, 0, 0);
    step(); set_id(0, 2, 2, 0, 0, 0); ex_result = 8'h99;
    push("alu_chain", 1, 1, 1, 0, 8'h2A, 0, 0, 0);
    step(); set_id(1, 0, 0, 4, 1, 0);
    push("invalid_ex_no_fwd", 0, 1, 0, 0, 0, 0, 0, 0);
    step(); set_id(1, 4, 4, 7, 1, 0); ex_result = 8'h11;
    push("or_in_ex", 1, 1, 0, 0, 0, 0, 0, 0);
    step(); set_id(1, 4, 6, 3, 1, 0); ex_result = 8'h33; set_wb(4, 8'h22);
    push("mem_beats_wb", 1, 1, 1, 1, 8'h11, 8'h11, 0, 0);
    step(); set_wb(4, 8'h22);
    push("wb_only", 1, 1, 1, 0, 8'h22, 0, 0, 0);
    step(); set_id(1, 0, 0, 5, 1, 1);
    push("before_load", 0, 1, 0, 0, 0, 0, 0, 0);
    step(); set_id(1, 5, 5, 6, 1, 0); ex_result = 8'h40;
    push("load_use_stall", 1, 0, 0, 0, 0, 0, 0, 0);
    step(); set_id(1, 5, 5, 6, 1, 0);
    push("load_bubble", 0, 1, 0, 0, 0, 0, 1, 1);
    step(); set_wb(5, 8'h77);
    push("load_use_wb", 1, 1, 1, 1, 8'h77, 8'h77, 1, 1);
    step(); set_id(1, 1, 2, 0, 1, 0);
    push("r0_write_enter", 0, 1, 0, 0, 0, 0, 1, 1);
    step(); set_id(1, 0, 0, 2, 1, 0); ex_result = 8'h55; set_wb(0, 8'h66);
    push("r0_in_ex", 1, 1, 0, 0, 0, 0, 1, 1);
    step(); set_id(1, 0, 0, 5, 1, 1); set_wb(0, 8'h66);
    push("r0_never_fwd", 1, 1, 0, 0, 0, 0, 1, 1);
    step(); set_id(1, 5, 5, 6, 1, 0); flush = 1;
    push("flush_stall_ready", 1, 1, 0, 0, 0, 0, 1, 1);
    step();
    push("flush_bubble", 0, 1, 0, 0, 0, 0, 1, 1);
    step(); set_id(1, 0, 0, 5, 1, 1);
    push("pre_reset_load", 0, 1, 0, 0, 0, 0, 1, 1);
    step(); set_id(1, 5, 5, 6, 1, 0);
    push("stall_before_reset", 1, 0, 0, 0, 0, 0, 1, 1);
    step(); set_id(1, 5, 5, 6, 1, 0); reset = 1;
    push("reset_mid_bubble", 0, 1, 0, 0, 0, 0, 0, 0);
    step(); reset = 0;
    push("after_reset", 0, 1, 0, 0, 0, 0, 0, 0);

    // A repeated self-dependent load stalls on every other cycle.
    for (int k = 0; k < 42; k++) begin
      step(); set_id(1, 5, 0, 5, 1, 1);
      push($sformatf("sat_%0d", k), k % 2, (k % 2 == 1) ? 0 : 1, 0, 0, 0, 0,
           k / 2, (k / 2 > 15) ? 15 : k / 2);
    end
    step();

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
